// File: rtl/core_pkg.sv
// Shared VRF geometry, width typedefs and the word-request payload used by
// the request sequencer and its optional output slice.
package core_pkg;

  localparam int unsigned VRFStrbWidth = 16;
  localparam int unsigned VlenWidth    = 12;
  localparam int unsigned NumVrfWords  = 128;

  // Byte-offset bits inside a word and the widths of the un-truncated products.
  localparam int unsigned ByteOffW  = $clog2(VRFStrbWidth);
  localparam int unsigned ProdWidth = VlenWidth + 3;
  localparam int unsigned WordIdxW  = ProdWidth - ByteOffW;

  typedef logic [VRFStrbWidth-1:0]        vrf_strb_t;
  typedef logic [$clog2(VRFStrbWidth):0]  ele_cnt_t;
  typedef logic [VlenWidth-1:0]           vlen_t;
  typedef logic [$clog2(NumVrfWords)-1:0] vrf_addr_t;
  typedef logic [ProdWidth-1:0]           byte_idx_t;
  typedef logic [WordIdxW-1:0]            word_idx_t;

  typedef enum logic {IDLE, RUN} vrf_seq_state_e;

  typedef struct packed {
    vrf_addr_t addr;
    logic      first;
    logic      last;
    ele_cnt_t  skip_first;
    ele_cnt_t  skip_last;
  } vrf_req_t;

  // Element count to byte count; sew 0..3 means 1, 2, 4, 8 bytes per element.
  function automatic byte_idx_t scale_by_sew(vlen_t n, logic [1:0] sew);
    return byte_idx_t'(n) << sew;
  endfunction

endpackage

// File: rtl/vrf_req_sequencer_if.sv
// Descriptor-in / word-request-out bundle of the VRF request sequencer.
// master: the sequencer; slave: the dispatcher and write-port arbiter side.
interface vrf_req_sequencer_if;
  import core_pkg::*;

  logic       op_valid_i;
  logic       op_ready_o;
  vlen_t      op_vstart_i;
  vlen_t      op_vl_i;
  logic [1:0] op_sew_i;
  logic [4:0] op_vd_i;

  logic       req_valid_o;
  logic       req_ready_i;
  vrf_addr_t  req_addr_o;
  logic       req_first_o;
  logic       req_last_o;
  ele_cnt_t   req_skip_first_o;
  ele_cnt_t   req_skip_last_o;
  logic       done_o;

  modport master (
    input  op_valid_i, op_vstart_i, op_vl_i, op_sew_i, op_vd_i, req_ready_i,
    output op_ready_o, req_valid_o, req_addr_o, req_first_o, req_last_o,
           req_skip_first_o, req_skip_last_o, done_o
  );

  modport slave (
    output op_valid_i, op_vstart_i, op_vl_i, op_sew_i, op_vd_i, req_ready_i,
    input  op_ready_o, req_valid_o, req_addr_o, req_first_o, req_last_o,
           req_skip_first_o, req_skip_last_o, done_o
  );
endinterface

// File: rtl/vrf_seq_spill_reg.sv
// Generic 2-entry valid/ready slice: full throughput, and in_ready depends
// only on local flops, so out_ready never reaches the upstream logic.
module vrf_seq_spill_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic a_full_q, b_full_q;
  T     a_data_q, b_data_q;
  logic a_fill, a_drain, b_fill, b_drain;

  assign a_fill  = in_valid && in_ready;
  assign a_drain = a_full_q && !b_full_q;
  assign b_fill  = a_drain && !out_ready;
  assign b_drain = b_full_q && out_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else begin
      if (a_fill || a_drain) a_full_q <= a_fill;
      if (b_fill || b_drain) b_full_q <= b_fill;
    end
  end

  // NOTE: payload flops carry no reset; the full flags alone qualify them.
  always_ff @(posedge clk_i) begin
    if (a_fill) a_data_q <= in_data;
    if (b_fill) b_data_q <= a_data_q;
  end

  assign in_ready  = !a_full_q || !b_full_q;
  assign out_valid = a_full_q || b_full_q;
  assign out_data  = b_full_q ? b_data_q : a_data_q;

endmodule

// File: rtl/vrf_req_sequencer.sv
// Turns one vector-op descriptor into per-VRF-word requests with first/last
// flags and byte skips. VRF_REQ_SEQ_OUT_REG_EN adds a spill slice on the outputs.
module vrf_req_sequencer
  import core_pkg::*;
#(
  parameter int unsigned WordsPerReg = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  vrf_req_sequencer_if.master bus
);

  vrf_seq_state_e state_q, state_d;

  word_idx_t  cur_q, first_word_q, last_word_q;
  ele_cnt_t   skip_first_q, skip_last_q;
  logic [4:0] vd_q;
  logic       empty_pend_q;

  logic      op_ready, op_hs, op_active;
  byte_idx_t sb, eb_end, eb_end_m1, eb_end_neg;
  logic      core_valid, core_ready, core_hs, done_raw;
  vrf_req_t  core_req;
  vrf_addr_t base_addr;

  assign op_ready  = (state_q == IDLE);
  assign op_hs     = bus.op_valid_i && op_ready;
  assign op_active = (bus.op_vstart_i < bus.op_vl_i);

  assign sb         = scale_by_sew(bus.op_vstart_i, bus.op_sew_i);
  assign eb_end     = scale_by_sew(bus.op_vl_i, bus.op_sew_i);
  assign eb_end_m1  = eb_end - byte_idx_t'(1);
  // (W - end mod W) mod W is just the low bits of the negated byte end.
  assign eb_end_neg = byte_idx_t'(0) - eb_end;

  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q        <= '0;
      first_word_q <= '0;
      last_word_q  <= '0;
      skip_first_q <= '0;
      skip_last_q  <= '0;
      vd_q         <= '0;
      empty_pend_q <= 1'b0;
    end else begin
      empty_pend_q <= op_hs && !op_active;
      if (op_hs && op_active) begin
        cur_q        <= sb[ProdWidth-1:ByteOffW];
        first_word_q <= sb[ProdWidth-1:ByteOffW];
        last_word_q  <= eb_end_m1[ProdWidth-1:ByteOffW];
        skip_first_q <= ele_cnt_t'(sb[ByteOffW-1:0]);
        skip_last_q  <= ele_cnt_t'(eb_end_neg[ByteOffW-1:0]);
        vd_q         <= bus.op_vd_i;
      end else if (core_hs) begin
        cur_q <= cur_q + word_idx_t'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (op_hs && op_active) state_d = RUN;
      RUN:  if (core_hs && core_req.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Truncation to vrf_addr_t is the intended register-group wrap.
  assign base_addr = vrf_addr_t'(32'(vd_q) * 32'(WordsPerReg));

  // NOTE: every comb output gets a default first, so no latch is inferred.
  always_comb begin
    core_valid = 1'b0;
    core_req   = '0;
    if (state_q == RUN) begin
      core_valid          = 1'b1;
      core_req.addr       = base_addr + vrf_addr_t'(cur_q);
      core_req.first      = (cur_q == first_word_q);
      core_req.last       = (cur_q == last_word_q);
      core_req.skip_first = core_req.first ? skip_first_q : '0;
      core_req.skip_last  = core_req.last  ? skip_last_q  : '0;
    end
  end

  assign core_hs = core_valid && core_ready;

`ifdef VRF_REQ_SEQ_OUT_REG_EN
  vrf_req_t out_req;

  vrf_seq_spill_reg #(.T(vrf_req_t)) u_spill (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (core_valid),
    .in_ready  (core_ready),
    .in_data   (core_req),
    .out_valid (bus.req_valid_o),
    .out_ready (bus.req_ready_i),
    .out_data  (out_req)
  );

  assign bus.req_addr_o       = out_req.addr;
  assign bus.req_first_o      = out_req.first;
  assign bus.req_last_o       = out_req.last;
  assign bus.req_skip_first_o = out_req.skip_first;
  assign bus.req_skip_last_o  = out_req.skip_last;
  assign done_raw = bus.req_valid_o && bus.req_ready_i && out_req.last;
`else
  assign core_ready           = bus.req_ready_i;
  assign bus.req_valid_o      = core_valid;
  assign bus.req_addr_o       = core_req.addr;
  assign bus.req_first_o      = core_req.first;
  assign bus.req_last_o       = core_req.last;
  assign bus.req_skip_first_o = core_req.skip_first;
  assign bus.req_skip_last_o  = core_req.skip_last;
  assign done_raw = core_hs && core_req.last;
`endif

  // A reset landing on the final handshake drops the op, so no done either.
  assign bus.done_o     = (empty_pend_q || done_raw) && !rst_i;
  assign bus.op_ready_o = op_ready;

endmodule

// File: tb/tb_vrf_req_sequencer.sv
// Directed bench for vrf_req_sequencer (W = 16, WordsPerReg = 4, default build).
module tb_vrf_req_sequencer;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vrf_req_sequencer_if bus();

  vrf_req_sequencer #(.WordsPerReg(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_op_ready"}, 32'(bus.op_ready_o), 1);
    check({tag, "_valid"},    32'(bus.req_valid_o), 0);
    check({tag, "_done"},     32'(bus.done_o), 0);
    check({tag, "_first"},    32'(bus.req_first_o), 0);
    check({tag, "_last"},     32'(bus.req_last_o), 0);
    check({tag, "_addr"},     32'(bus.req_addr_o), 0);
    check({tag, "_skip_f"},   32'(bus.req_skip_first_o), 0);
    check({tag, "_skip_l"},   32'(bus.req_skip_last_o), 0);
  endtask

  // Presents a descriptor for one cycle; returns in the cycle after the handshake.
  task automatic send_op(input int vstart, input int vl, input int sew, input int vd);
    tick();
    bus.op_vstart_i = vlen_t'(vstart);
    bus.op_vl_i     = vlen_t'(vl);
    bus.op_sew_i    = 2'(sew);
    bus.op_vd_i     = 5'(vd);
    bus.op_valid_i  = 1'b1;
    #1;
    check("op_ready_at_hs", 32'(bus.op_ready_o), 1);
    tick();
    bus.op_valid_i = 1'b0;
  endtask

  // Checks one request cycle with req_ready_i high, then advances a cycle.
  task automatic expect_req(input string tag, input int addr, input int first,
                            input int last, input int sf, input int sl, input int done);
    check({tag, "_valid"},    32'(bus.req_valid_o), 1);
    check({tag, "_op_ready"}, 32'(bus.op_ready_o), 0);
    check({tag, "_addr"},     32'(bus.req_addr_o), 32'(addr));
    check({tag, "_first"},    32'(bus.req_first_o), 32'(first));
    check({tag, "_last"},     32'(bus.req_last_o), 32'(last));
    check({tag, "_skip_f"},   32'(bus.req_skip_first_o), 32'(sf));
    check({tag, "_skip_l"},   32'(bus.req_skip_last_o), 32'(sl));
    check({tag, "_done"},     32'(bus.done_o), 32'(done));
    tick();
  endtask

  // Backpressure op: sew=0 vstart=20 vl=90 vd=31 -> words 1..5, addr wraps past 127.
  int bp_addr [5] = '{125, 126, 127, 0, 1};
  logic [15:0] bp_pat = 16'b0110_1001_1100_1010;

  initial begin
    bus.op_valid_i  = 1'b0;
    bus.op_vstart_i = '0;
    bus.op_vl_i     = '0;
    bus.op_sew_i    = '0;
    bus.op_vd_i     = '0;
    bus.req_ready_i = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");

    // Single full word, no skips.
    bus.req_ready_i = 1'b1;
    send_op(0, 16, 0, 2);
    expect_req("t1", 8, 1, 1, 0, 0, 1);
    check_idle_outputs("t1_after");

    // Five words, leading skip of 3 halfwords.
    send_op(3, 40, 1, 1);
    for (int i = 0; i < 5; i++)
      expect_req($sformatf("t2_w%0d", i), 4 + i, (i == 0) ? 1 : 0, (i == 4) ? 1 : 0,
                 (i == 0) ? 6 : 0, 0, (i == 4) ? 1 : 0);
    check_idle_outputs("t2_after");

    // Single word with both skips.
    send_op(1, 2, 2, 3);
    expect_req("t3", 12, 1, 1, 4, 8, 1);

    // Empty ops: vl=0, then vstart == vl.
    send_op(0, 0, 0, 0);
    check("t4a_valid", 32'(bus.req_valid_o), 0);
    check("t4a_done",  32'(bus.done_o), 1);
    check("t4a_op_ready", 32'(bus.op_ready_o), 1);
    tick();
    check("t4a_done_clear", 32'(bus.done_o), 0);
    check("t4a_valid_after", 32'(bus.req_valid_o), 0);
    send_op(5, 5, 0, 0);
    check("t4b_valid", 32'(bus.req_valid_o), 0);
    check("t4b_done",  32'(bus.done_o), 1);
    tick();
    check("t4b_done_clear", 32'(bus.done_o), 0);
    check("t4b_valid_after", 32'(bus.req_valid_o), 0);

    // Backpressure: compare against the expected word every cycle, stalled or not.
    bus.req_ready_i = 1'b0;
    send_op(20, 90, 0, 31);
    begin
      int k = 0;
      for (int c = 0; c < 40 && k < 5; c++) begin
        bus.req_ready_i = bp_pat[c % 16];
        #1;
        check("bp_valid",    32'(bus.req_valid_o), 1);
        check("bp_op_ready", 32'(bus.op_ready_o), 0);
        check("bp_addr",     32'(bus.req_addr_o), 32'(bp_addr[k]));
        check("bp_first",    32'(bus.req_first_o), (k == 0) ? 1 : 0);
        check("bp_last",     32'(bus.req_last_o), (k == 4) ? 1 : 0);
        check("bp_skip_f",   32'(bus.req_skip_first_o), (k == 0) ? 4 : 0);
        check("bp_skip_l",   32'(bus.req_skip_last_o), (k == 4) ? 6 : 0);
        check("bp_done",     32'(bus.done_o), (bus.req_ready_i && k == 4) ? 1 : 0);
        if (bus.req_ready_i) k++;
        tick();
      end
      check("bp_handshakes", 32'(k), 5);
    end
    bus.req_ready_i = 1'b1;
    #1;
    check_idle_outputs("bp_after");

    // Reset after the second handshake, then a normal op.
    send_op(3, 40, 1, 1);
    expect_req("rst_w0", 4, 1, 0, 6, 0, 0);
    expect_req("rst_w1", 5, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    send_op(1, 2, 2, 3);
    expect_req("rst_new", 12, 1, 1, 4, 8, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
